syscall_print_string: RTL and testbench

Sequential helper that services the MIPS `print_string` syscall ($v0 = 4) for the single-cycle CPU. It walks a NUL-terminated string in data memory, starting at the address in $a0, and streams the characters to the console sink over a valid/ready handshake. While it runs, it holds the CPU stalled. It sits between the syscall decode and the data memory / console, downstream of the register file ($v0/$a0) and upstream of the output sink.

---
 rtl/syscall_print_string.sv | 113 +++++++++++
 tb/tb_syscall_print_string.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_print_string.sv
// rtl/syscall_print_string.sv - MIPS print_string syscall streamer (optional SYSCALL_PRINT_STATS_EN adds chars_total)
module syscall_print_string #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      str_addr,
  output logic             mem_re,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             out_valid,
  output logic [7:0]       out_char,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             truncated,
  output logic [LEN_W-1:0] length
`ifdef SYSCALL_PRINT_STATS_EN
  ,
  output logic [31:0]      chars_total
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

  state_t           state;
  logic [31:0]      ptr;
  logic [31:0]      word;
  logic [31:0]      ptr_inc;
  logic [LEN_W-1:0] length_inc;
  logic [7:0]       cur_byte;
  logic             fire;

  // Big-endian lane select: byte 0 of a word lives in its top bits.
  always_comb begin
    cur_byte = 8'h00;
    case (ptr[1:0])
      2'd0: cur_byte = word[31:24];
      2'd1: cur_byte = word[23:16];
      2'd2: cur_byte = word[15:8];
      2'd3: cur_byte = word[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  assign ptr_inc    = ptr + 32'd1;
  assign length_inc = length + LEN_W'(1);
  assign fire       = (state == EMIT) && (cur_byte != 8'h00) && out_ready;

  assign mem_re    = (state == FETCH);
  assign mem_addr  = {ptr[31:2], 2'b00};
  assign out_valid = (state == EMIT) && (cur_byte != 8'h00);
  assign out_char  = out_valid ? cur_byte : 8'h00;
  assign done      = (state == DONE);
  // Combinational so the CPU stalls in the very cycle the syscall decodes.
  assign busy      = ((state == IDLE) && start) || (state == FETCH) ||
                     (state == WAIT) || (state == EMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 32'd0;
      word      <= 32'd0;
      length    <= '0;
      truncated <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr       <= str_addr;
            length    <= '0;
            truncated <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          word  <= mem_rdata;
          state <= EMIT;
        end
        EMIT: begin
          if (cur_byte == 8'h00) begin
            state <= DONE;
          end else if (out_ready) begin
            ptr    <= ptr_inc;
            length <= length_inc;
            if (length_inc == LEN_W'(MAX_LEN)) begin
              truncated <= 1'b1;
              state     <= DONE;
            end else if (ptr_inc[1:0] == 2'b00) begin
              state <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYSCALL_PRINT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      chars_total <= 32'd0;
    end else if (fire) begin
      chars_total <= chars_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_syscall_print_string.sv
// tb/tb_syscall_print_string.sv - self-checking bench for syscall_print_string
module tb_syscall_print_string;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, out_ready;
  logic [31:0] str_addr, mem_addr, mem_rdata;
  logic        mem_re, out_valid, busy, done, truncated;
  logic [7:0]  out_char;
  logic [15:0] length;

  logic        start4, out_ready4;
  logic [31:0] mem_addr4, mem_rdata4;
  logic        mem_re4, out_valid4, busy4, done4, truncated4;
  logic [7:0]  out_char4;
  logic [15:0] length4;

`ifdef SYSCALL_PRINT_STATS_EN
  logic [31:0] chars_total, chars_total4;
`endif

  syscall_print_string u_dut (
    .clk(clk), .reset(reset), .start(start), .str_addr(str_addr),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .busy(busy), .done(done), .truncated(truncated), .length(length)
`ifdef SYSCALL_PRINT_STATS_EN
    , .chars_total(chars_total)
`endif
  );

  syscall_print_string #(.MAX_LEN(4), .LEN_W(16)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .str_addr(32'h0000_0400),
    .mem_re(mem_re4), .mem_addr(mem_addr4), .mem_rdata(mem_rdata4),
    .out_valid(out_valid4), .out_char(out_char4), .out_ready(out_ready4),
    .busy(busy4), .done(done4), .truncated(truncated4), .length(length4)
`ifdef SYSCALL_PRINT_STATS_EN
    , .chars_total(chars_total4)
`endif
  );

  logic [7:0] mem [0:4095];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {mem[12'(a)], mem[12'(a + 32'd1)], mem[12'(a + 32'd2)], mem[12'(a + 32'd3)]};
  endfunction

  // Data is only valid the cycle after a strobe; garbage otherwise.
  always @(posedge clk) begin
    mem_rdata  <= mem_re  ? rd_word(mem_addr)  : 32'hDEAD_BEEF;
    mem_rdata4 <= mem_re4 ? rd_word(mem_addr4) : 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char  = 8'h00;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_char", 32'(out_char), 32'(prev_char));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_char", 32'(out_char), 32'hFFFF_FFFF);
        else check("char", 32'(out_char), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = out_valid && !out_ready && !reset;
    prev_char  = out_char;
  end

  typedef struct {
    logic [31:0] addr;
    logic [63:0] txt;
    int          n;
    int          lo;
    int          hi;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];
  int   exp_total = 0;

  task automatic put_str(input logic [31:0] addr, input logic [79:0] txt, input int n);
    for (int i = 0; i < n; i++) mem[12'(addr + 32'(i))] = txt[8*(n-1-i) +: 8];
    mem[12'(addr + 32'(n))] = 8'h00;
  endtask

  task automatic run_case(input vec_t v);
    int cyc;
    int got;
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.txt[8*(v.n-1-i) +: 8]);
    start     = 1'b1;
    str_addr  = v.addr;
    out_ready = 1'b1;
    @(negedge clk);
    check("busy_at_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    got = -1;
    while (cyc < 200 && got < 0) begin
      out_ready = (cyc >= v.lo && cyc <= v.hi) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (cyc == 1) begin
        check("fetch_re", 32'(mem_re), 32'd1);
        check("fetch_addr", mem_addr, {v.addr[31:2], 2'b00});
      end
      if (done) got = cyc;
      else check("busy_running", 32'(busy), 32'd1);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    check("done_cycle", 32'(got), 32'(v.exp_done));
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("length", 32'(length), 32'(v.n));
    check("truncated", 32'(truncated), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    exp_total += v.n;
`ifdef SYSCALL_PRINT_STATS_EN
    check("chars_total", chars_total, 32'(exp_total));
`endif
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int nchar;
    int ndone;
    int gotd;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h5A;
    vecs[0] = '{32'h0000_0100, 64'("Hi"),    2, 99, 0, 6};
    vecs[1] = '{32'h0000_0103, 64'("abc"),   3, 99, 0, 9};
    vecs[2] = '{32'h0000_0100, 64'("Hi"),    2, 3,  5, 9};
    vecs[3] = '{32'h0000_0200, 64'(""),      0, 99, 0, 4};
    vecs[4] = '{32'hFFFF_FFFE, 64'("wxyz"),  4, 99, 0, 10};
    vecs[5] = '{32'h0000_0301, 64'("Hello"), 5, 99, 0, 11};
    for (int i = 0; i < 6; i++) put_str(vecs[i].addr, 80'(vecs[i].txt), vecs[i].n);
    put_str(32'h0000_0400, 80'("0123456789"), 10);

    reset = 1'b1; start = 1'b0; str_addr = 32'd0; out_ready = 1'b0;
    start4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_char", 32'(out_char), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_truncated", 32'(truncated), 32'd0);
    check("rst_length", 32'(length), 32'd0);
`ifdef SYSCALL_PRINT_STATS_EN
    check("rst_chars_total", chars_total, 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_case(vecs[i]);

    // Abort mid-string: reset during EMIT, then the same string must print cleanly.
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h69);
    start = 1'b1; str_addr = 32'h0000_0100; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    exp_total = 0;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_length", 32'(length), 32'd0);
    check("abort_done", 32'(done), 32'd0);
`ifdef SYSCALL_PRINT_STATS_EN
    check("abort_chars_total", chars_total, 32'd0);
`endif
    @(posedge clk); #1;
    run_case(vecs[0]);

    // MAX_LEN=4 instance against a 10-character string.
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    nchar = 0; ndone = 0; gotd = -1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (out_valid4) begin
        check("trunc_char", 32'(out_char4), 32'h30 + 32'(nchar));
        nchar++;
      end
      if (done4) begin
        ndone++;
        if (gotd < 0) gotd = c;
      end
      @(posedge clk); #1;
    end
    check("trunc_count", 32'(nchar), 32'd4);
    check("trunc_done_pulses", 32'(ndone), 32'd1);
    check("trunc_done_cycle", 32'(gotd), 32'd7);
    check("trunc_flag", 32'(truncated4), 32'd1);
    check("trunc_length", 32'(length4), 32'd4);
`ifdef SYSCALL_PRINT_STATS_EN
    check("trunc_chars_total", chars_total4, 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
